// File: rtl/stream_downsizer.sv
// Splits each IN_DW-bit upstream word into RATIO narrower beats, least-significant slice first.
// One beat per cycle is sustained: a new word may load on the same edge that retires the last beat.

module stream_downsizer #(
  parameter int unsigned IN_DW = 32,
  parameter int unsigned RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_valid,
  input  logic [IN_DW-1:0]         up_data,
  output logic                     up_ready,
  output logic                     down_valid,
  output logic [IN_DW/RATIO-1:0]   down_data,
  output logic                     down_last,
  input  logic                     down_ready
);

  localparam int unsigned OUT_DW = IN_DW / RATIO;
  localparam int unsigned CW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(RATIO - 1);

  if (RATIO < 1 || (IN_DW % RATIO) != 0) begin : g_bad_param
    $error("stream_downsizer: IN_DW must be a non-zero multiple of RATIO");
  end

  logic [IN_DW-1:0]  r_buf;
  logic [CW-1:0]     r_cnt;
  logic              r_valid;

  logic              w_up_hs;
  logic              w_dn_hs;
  logic              w_last;
  logic [CW-1:0]     w_cnt_d;
  logic              w_valid_d;
  logic [OUT_DW-1:0] w_slice;

  assign w_last   = (r_cnt == LastCnt);
  // Room for a new word only when idle or when the final beat leaves this cycle.
  assign up_ready = !r_valid || (down_ready && w_last);
  assign w_up_hs  = up_valid && up_ready;
  assign w_dn_hs  = r_valid && down_ready;

  always_comb begin
    w_cnt_d   = r_cnt;
    w_valid_d = r_valid;
    if (w_up_hs) begin
      w_cnt_d   = '0;
      w_valid_d = 1'b1;
    end else if (w_dn_hs) begin
      if (w_last) begin
        w_cnt_d   = '0;
        w_valid_d = 1'b0;
      end else begin
        w_cnt_d = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_valid <= w_valid_d;
    end
  end

  // Data path needs no reset: it is only observed while r_valid is set.
  always_ff @(posedge clk) begin
    if (w_up_hs) begin
      r_buf <= up_data;
    end
  end

  always_comb begin
    w_slice = r_buf[OUT_DW-1:0];
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (r_cnt == CW'(i)) begin
        w_slice = r_buf[i*OUT_DW +: OUT_DW];
      end
    end
  end

  assign down_valid = r_valid;
  assign down_data  = w_slice;
  assign down_last  = w_last;

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: vector table, hand-written reset sequences and a randomised
// run against a beat-queue reference model. Second instance covers RATIO=1.

module tb_stream_downsizer;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic [31:0] up_data;
  logic        up_ready;
  logic        down_valid;
  logic [7:0]  down_data;
  logic        down_last;
  logic        down_ready;

  logic        up_valid1;
  logic [7:0]  up_data1;
  logic        up_ready1;
  logic        down_valid1;
  logic [7:0]  down_data1;
  logic        down_last1;
  logic        down_ready1;

  int n_checks;
  int n_fail;

  stream_downsizer #(.IN_DW(32), .RATIO(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_ready (down_ready)
  );

  stream_downsizer #(.IN_DW(8), .RATIO(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid1),
    .up_data    (up_data1),
    .up_ready   (up_ready1),
    .down_valid (down_valid1),
    .down_data  (down_data1),
    .down_last  (down_last1),
    .down_ready (down_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] ud;
    logic        dr;
    logic        dv;
    logic [7:0]  dd;
    logic        dl;
    logic        ur;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic uv, input logic [31:0] ud, input logic dr,
                     input logic dv, input logic [7:0] dd, input logic dl, input logic ur);
    vec_t v;
    v.uv = uv; v.ud = ud; v.dr = dr; v.dv = dv; v.dd = dd; v.dl = dl; v.ur = ur;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word into the RATIO=4 instance and expect its four beats with down_ready high.
  task automatic send_word(input string tag, input logic [31:0] w);
    up_valid   = 1'b1;
    up_data    = w;
    down_ready = 1'b1;
    #4;
    chk({tag, "_accept_ur"}, {31'd0, up_ready}, 32'd1);
    step();
    up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("%s_b%0d_dv", tag, i), {31'd0, down_valid}, 32'd1);
      chk($sformatf("%s_b%0d_dd", tag, i), {24'd0, down_data}, {24'd0, w[i*8 +: 8]});
      chk($sformatf("%s_b%0d_dl", tag, i), {31'd0, down_last}, (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    #4;
    chk({tag, "_idle_dv"}, {31'd0, down_valid}, 32'd0);
    step();
  endtask

  initial begin
    int          words;
    int          cyc;
    int          exp_ur;
    logic        hs_up;
    logic        hs_dn;
    beat_t       b;
    logic [31:0] w;

    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    up_valid    = 1'b1;
    up_data     = 32'hCAFEF00D;
    down_ready  = 1'b1;
    up_valid1   = 1'b1;
    up_data1    = 8'hA5;
    down_ready1 = 1'b1;

    // Reset with up_valid asserted
    step();
    step();
    #4;
    chk("rst_dv", {31'd0, down_valid}, 32'd0);
    chk("rst_ur", {31'd0, up_ready}, 32'd1);
    chk("rst_dl", {31'd0, down_last}, 32'd0);
    chk("rst_r1_dv", {31'd0, down_valid1}, 32'd0);
    chk("rst_r1_dl", {31'd0, down_last1}, 32'd1);
    chk("rst_r1_ur", {31'd0, up_ready1}, 32'd1);
    up_valid  = 1'b0;
    up_valid1 = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #4;
      chk($sformatf("post_rst%0d_dv", i), {31'd0, down_valid}, 32'd0);
    end
    step();

    // Single word, back-to-back words, backpressure
    add(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
    add(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b1, 32'h03020100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
    add(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
    add(1'b0, 32'h0,        1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
    add(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      up_valid   = tbl[i].uv;
      up_data    = tbl[i].ud;
      down_ready = tbl[i].dr;
      #4;
      chk($sformatf("vec%0d_dv", i), {31'd0, down_valid}, {31'd0, tbl[i].dv});
      chk($sformatf("vec%0d_ur", i), {31'd0, up_ready}, {31'd0, tbl[i].ur});
      chk($sformatf("vec%0d_dl", i), {31'd0, down_last}, {31'd0, tbl[i].dl});
      if (tbl[i].dv) begin
        chk($sformatf("vec%0d_dd", i), {24'd0, down_data}, {24'd0, tbl[i].dd});
      end
      step();
    end
    up_valid = 1'b0;

    // Reset in the middle of a word (beat 1 showing)
    up_valid   = 1'b1;
    up_data    = 32'h44332211;
    down_ready = 1'b1;
    step();
    up_valid = 1'b0;
    step();
    #1;
    chk("mid_beat1_dd", {24'd0, down_data}, 32'h22);
    rst = 1'b0;
    #1;
    chk("mid_async_dv", {31'd0, down_valid}, 32'd0);
    chk("mid_async_ur", {31'd0, up_ready}, 32'd1);
    step();
    rst = 1'b1;
    step();
    #4;
    chk("mid_after_dv", {31'd0, down_valid}, 32'd0);
    step();
    send_word("after_rst", 32'h88776655);

    // Same for RATIO=1: stall the beat, reset, then a fresh word
    up_valid1   = 1'b1;
    up_data1    = 8'h11;
    down_ready1 = 1'b0;
    step();
    up_valid1 = 1'b0;
    #1;
    chk("r1_beat_dv", {31'd0, down_valid1}, 32'd1);
    chk("r1_beat_dd", {24'd0, down_data1}, 32'h11);
    chk("r1_stall_ur", {31'd0, up_ready1}, 32'd0);
    rst = 1'b0;
    #1;
    chk("r1_async_dv", {31'd0, down_valid1}, 32'd0);
    step();
    rst = 1'b1;
    step();
    #4;
    chk("r1_after_dv", {31'd0, down_valid1}, 32'd0);
    up_valid1   = 1'b1;
    up_data1    = 8'h55;
    down_ready1 = 1'b1;
    step();
    up_data1 = 8'h66;
    #4;
    chk("r1_b0_dv", {31'd0, down_valid1}, 32'd1);
    chk("r1_b0_dd", {24'd0, down_data1}, 32'h55);
    chk("r1_b0_dl", {31'd0, down_last1}, 32'd1);
    chk("r1_b0_ur", {31'd0, up_ready1}, 32'd1);
    step();
    up_valid1 = 1'b0;
    #4;
    chk("r1_b1_dd", {24'd0, down_data1}, 32'h66);
    chk("r1_b1_dv", {31'd0, down_valid1}, 32'd1);
    step();
    #4;
    chk("r1_idle_dv", {31'd0, down_valid1}, 32'd0);
    step();

    // Randomised traffic against the beat-queue model
    words = 0;
    cyc   = 0;
    up_valid = 1'b0;
    model_q.delete();
    while (words < 2000 && cyc < 40000) begin
      if (!up_valid) begin
        up_valid = ($urandom_range(0, 3) != 0);
        up_data  = $urandom;
      end
      down_ready = ($urandom_range(0, 3) != 0);
      #4;
      exp_ur = (model_q.size() == 0 || (model_q.size() == 1 && down_ready)) ? 1 : 0;
      chk("rnd_dv", {31'd0, down_valid}, (model_q.size() != 0) ? 32'd1 : 32'd0);
      chk("rnd_ur", {31'd0, up_ready}, exp_ur);
      if (down_valid && model_q.size() != 0) begin
        chk("rnd_dd", {24'd0, down_data}, {24'd0, model_q[0].data});
        chk("rnd_dl", {31'd0, down_last}, {31'd0, model_q[0].last});
      end
      hs_up = up_valid && up_ready;
      hs_dn = down_valid && down_ready;
      if (hs_dn && model_q.size() != 0) begin
        b = model_q.pop_front();
      end
      if (hs_up) begin
        w = up_data;
        for (int i = 0; i < 4; i++) begin
          b.data = w[i*8 +: 8];
          b.last = (i == 3);
          model_q.push_back(b);
        end
        words++;
      end
      step();
      if (hs_up) begin
        up_valid = 1'b0;
      end
      cyc++;
    end
    chk("rnd_words_done", words, 32'd2000);

    up_valid   = 1'b0;
    down_ready = 1'b1;
    cyc = 0;
    while (model_q.size() != 0 && cyc < 20) begin
      #4;
      chk("drain_dv", {31'd0, down_valid}, 32'd1);
      if (down_valid) begin
        chk("drain_dd", {24'd0, down_data}, {24'd0, model_q[0].data});
        chk("drain_dl", {31'd0, down_last}, {31'd0, model_q[0].last});
        b = model_q.pop_front();
      end
      step();
      cyc++;
    end
    #4;
    chk("drain_empty", model_q.size(), 32'd0);
    chk("drain_idle_dv", {31'd0, down_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
